// File: rtl/pcie_tx_arbiter_if.sv
// Handshake bundle for the PCIe TX arbiter: two requester AXI-stream
// inputs and the single AXI-stream output toward the PCIe core.
interface pcie_tx_arbiter_if;
    logic [63:0] r0_tdata;
    logic [7:0]  r0_tkeep;
    logic [3:0]  r0_tuser;
    logic        r0_tlast;
    logic        r0_tvalid;
    logic        r0_tready;

    logic [63:0] r1_tdata;
    logic [7:0]  r1_tkeep;
    logic [3:0]  r1_tuser;
    logic        r1_tlast;
    logic        r1_tvalid;
    logic        r1_tready;

    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic [3:0]  s_axis_tx_tuser;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tready;

    // Arbiter view: consumes requester beats, drives the core stream
    modport master (
        input  r0_tdata, r0_tkeep, r0_tuser, r0_tlast, r0_tvalid,
        output r0_tready,
        input  r1_tdata, r1_tkeep, r1_tuser, r1_tlast, r1_tvalid,
        output r1_tready,
        output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser,
        output s_axis_tx_tlast, s_axis_tx_tvalid,
        input  s_axis_tx_tready
    );

    // Environment view: requesters and the core stream sink
    modport slave (
        output r0_tdata, r0_tkeep, r0_tuser, r0_tlast, r0_tvalid,
        input  r0_tready,
        output r1_tdata, r1_tkeep, r1_tuser, r1_tlast, r1_tvalid,
        input  r1_tready,
        input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser,
        input  s_axis_tx_tlast, s_axis_tx_tvalid,
        output s_axis_tx_tready
    );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// PCIe TX arbiter: shares the core transmit stream between two requesters
// (round robin on ties) and the core's own config-completion traffic, which
// takes priority but never interrupts a packet already in flight.
module pcie_tx_arbiter #(
    parameter int unsigned BUF_MIN = 1,
    parameter int unsigned DROP_W  = 16
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic              user_lnk_up,
    input  logic [5:0]        tx_buf_av,
    input  logic              tx_cfg_req,
    output logic              tx_cfg_gnt,
    input  logic              tx_err_drop,
    pcie_tx_arbiter_if.master bus,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CFG  = 2'd1;
    localparam logic [1:0] PKT0 = 2'd2;
    localparam logic [1:0] PKT1 = 2'd3;

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic              lastSrv_q, lastSrv_d;
    logic              cfgGnt_q;
    logic [DROP_W-1:0] dropCnt_q, dropCnt_d;
    logic              bufOk;

    // A zero threshold means the buffer level never blocks a new packet
    if (BUF_MIN == 0) begin : gNoBufCheck
        assign bufOk = 1'b1;
    end else begin : gBufCheck
        assign bufOk = ({26'd0, tx_buf_av} >= BUF_MIN);
    end

    // Next-state decision: config wins in IDLE, packets run to their tlast
    always_comb begin
        state_d   = state_q;
        lastSrv_d = lastSrv_q;
        case (state_q)
            IDLE: begin
                if (tx_cfg_req) begin
                    state_d = CFG;
                end else if (user_lnk_up && bufOk) begin
                    if (bus.r0_tvalid && (!bus.r1_tvalid || lastSrv_q)) begin
                        state_d   = PKT0;
                        lastSrv_d = 1'b0;
                    end else if (bus.r1_tvalid) begin
                        state_d   = PKT1;
                        lastSrv_d = 1'b1;
                    end
                end
            end
            CFG: begin
                if (!tx_cfg_req) begin
                    state_d = IDLE;
                end
            end
            PKT0: begin
                if (bus.r0_tvalid && bus.s_axis_tx_tready && bus.r0_tlast) begin
                    state_d = IDLE;
                end
            end
            PKT1: begin
                if (bus.r1_tvalid && bus.s_axis_tx_tready && bus.r1_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drop counter saturates at all-ones instead of wrapping
    always_comb begin
        dropCnt_d = dropCnt_q;
        if (tx_err_drop && (dropCnt_q != DROP_MAX)) begin
            dropCnt_d = dropCnt_q + DROP_ONE;
        end
    end

    // State, round-robin pointer, registered grant and drop counter
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q   <= IDLE;
            lastSrv_q <= 1'b1;
            cfgGnt_q  <= 1'b0;
            dropCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lastSrv_q <= lastSrv_d;
            cfgGnt_q  <= (state_d == CFG);
            dropCnt_q <= dropCnt_d;
        end
    end

    // Zero-latency pass-through of the granted requester; everything idle otherwise
    always_comb begin
        bus.s_axis_tx_tdata  = '0;
        bus.s_axis_tx_tkeep  = '0;
        bus.s_axis_tx_tuser  = '0;
        bus.s_axis_tx_tlast  = 1'b0;
        bus.s_axis_tx_tvalid = 1'b0;
        bus.r0_tready        = 1'b0;
        bus.r1_tready        = 1'b0;
        case (state_q)
            PKT0: begin
                bus.s_axis_tx_tdata  = bus.r0_tdata;
                bus.s_axis_tx_tkeep  = bus.r0_tkeep;
                bus.s_axis_tx_tuser  = bus.r0_tuser;
                bus.s_axis_tx_tlast  = bus.r0_tlast;
                bus.s_axis_tx_tvalid = bus.r0_tvalid;
                bus.r0_tready        = bus.s_axis_tx_tready;
            end
            PKT1: begin
                bus.s_axis_tx_tdata  = bus.r1_tdata;
                bus.s_axis_tx_tkeep  = bus.r1_tkeep;
                bus.s_axis_tx_tuser  = bus.r1_tuser;
                bus.s_axis_tx_tlast  = bus.r1_tlast;
                bus.s_axis_tx_tvalid = bus.r1_tvalid;
                bus.r1_tready        = bus.s_axis_tx_tready;
            end
            default: ;
        endcase
    end

    assign tx_cfg_gnt = cfgGnt_q;
    assign drop_cnt   = dropCnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/pcie_tx_arbiter.md
PCIE_TX_ARBITER -- requirements
Module: pcie_tx_arbiter

Interface
REQ-001 The block SHALL have parameter BUF_MIN, default 1, meaning the minimum tx_buf_av value required to start a packet.
REQ-002 The block SHALL have parameter DROP_W, default 16, meaning the width of the drop counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have these clock and reset ports:
- user_clk  input  1  single clock for all logic.
- user_rst_n  input  1  asynchronous reset, active low.
REQ-005 The block SHALL have these core-status ports:
- user_lnk_up  input  1  link up from the PCIe core.
- tx_buf_av  input  6  transmit buffers available in the core.
- tx_cfg_req  input  1  core requests the TX link for internal config completions.
- tx_cfg_gnt  output  1  arbiter grants the TX link to the core.
- tx_err_drop  input  1  core dropped the current TLP.
REQ-006 The block SHALL have these requester ports, for n = 0 and 1:
- rN_tdata  input  64  requester TLP data.
- rN_tkeep  input  8  byte enables.
- rN_tuser  input  4  sideband.
- rN_tlast  input  1  last beat.
- rN_tvalid  input  1  beat valid.
- rN_tready  output  1  beat accepted.
REQ-007 The block SHALL have these core TX-stream ports:
- s_axis_tx_tdata  output  64  TLP data to the core.
- s_axis_tx_tkeep  output  8  byte enables.
- s_axis_tx_tuser  output  4  sideband.
- s_axis_tx_tlast  output  1  last beat.
- s_axis_tx_tvalid  output  1  beat valid.
- s_axis_tx_tready  input  1  core ready.
REQ-008 The block SHALL have these status outputs:
- drop_cnt  output  DROP_W  saturating count of dropped TLPs.
- busy  output  1  high when not in IDLE.

Function
REQ-009 The block SHALL implement four states: IDLE, CFG, PKT0 and PKT1.
REQ-010 In IDLE, when tx_cfg_req=1, the block SHALL go to CFG next cycle; config has absolute priority over requesters.
REQ-011 In IDLE, when tx_cfg_req=0, user_lnk_up=1 and tx_buf_av>=BUF_MIN, the block SHALL go to PKTn for the chosen requester.
- Only r0_tvalid high: choose 0.
- Only r1_tvalid high: choose 1.
- Both high: choose the requester not equal to last_srv (round robin).
REQ-012 On entry to PKTn, last_srv SHALL be set to n; the reset value of last_srv is 1, so r0 wins the first tie.
REQ-013 In CFG, tx_cfg_gnt SHALL be 1 (registered); CFG returns to IDLE in the cycle after tx_cfg_req is sampled 0.
REQ-014 In PKTn, the output stream SHALL be a combinational pass-through of requester n with zero latency:
- s_axis_tx_tvalid = rN_tvalid.
- rN_tready = s_axis_tx_tready.
- data, keep, user and last follow requester n.
REQ-015 PKTn SHALL return to IDLE in the cycle after a beat with rN_tvalid & s_axis_tx_tready & rN_tlast.
REQ-016 A packet SHALL never be interrupted:
- tx_cfg_req, user_lnk_up falling and tx_buf_av falling are ignored until tlast is accepted.
- tx_cfg_gnt stays 0 in PKTn.
REQ-017 Outside PKTn, s_axis_tx_tvalid SHALL be 0 and rN_tready SHALL be 0 for both requesters.
REQ-018 In PKTn, the non-selected requester's tready SHALL be 0.
REQ-019 In IDLE/CFG, data, keep, user and last SHALL be driven to 0.
REQ-020 IDLE to PKTn SHALL take one cycle, so the first beat can transfer in the cycle after a grant decision.
REQ-021 On tx_err_drop=1 in any cycle, drop_cnt SHALL increment by 1 and saturate at all-ones without wrapping.
REQ-022 busy SHALL be 1 in CFG or PKTn and 0 in IDLE.
REQ-023 tx_buf_av SHALL be compared unsigned.
REQ-024 BUF_MIN=0 SHALL disable the buffer check.

Reset
REQ-025 While user_rst_n=0, outputs SHALL be:
- state IDLE, last_srv 1.
- tx_cfg_gnt 0, s_axis_tx_tvalid 0, r0_tready 0, r1_tready 0.
- drop_cnt 0, busy 0, data/keep/user/last 0.
REQ-026 Reset asserted mid-packet SHALL force IDLE immediately (asynchronously), with no partial-packet recovery.
REQ-027 After reset deasserts, the first arbitration SHALL occur on the first rising edge with user_rst_n=1.

Verification
REQ-028 The bench SHALL cover a tie with both requesters valid, 3-beat packets, tready=1 -> r0 packet beats 1-3, then r1 packet beats 1-3, then r0 again; no idle gap beyond one IDLE cycle between packets.
REQ-029 The bench SHALL cover tx_cfg_req=1 on the 2nd beat of an r1 packet -> tx_cfg_gnt stays 0 until after r1 tlast is accepted, then rises within 2 cycles; r0 is blocked while tx_cfg_req=1.
REQ-030 The bench SHALL cover tx_buf_av=0 with BUF_MIN=1 and r0 valid -> no grant, s_axis_tx_tvalid=0; tx_buf_av=3 -> PKT0 next cycle.
REQ-031 The bench SHALL cover tready toggling 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated, output data equals input order, and rN_tready mirrors s_axis_tx_tready.
REQ-032 The bench SHALL cover tx_err_drop pulsed 65540 times with DROP_W=16 -> drop_cnt=0xFFFF.
REQ-033 The bench SHALL cover user_rst_n low for 1 cycle mid-packet -> tvalid=0, busy=0 and drop_cnt=0 immediately.
